// File: rtl/fp_pkg.sv
// Shared constants and FSM state type for the compressed-float expander.
package fp_pkg;

    localparam int unsigned W_D     = 13;
    localparam int unsigned W_E     = 3;
    localparam int unsigned W_F     = 5;
    localparam int unsigned MAX_MAG = 3968;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        OUT
    } state_t;

endpackage

// File: rtl/fp_expand.sv
// Expands {S, E, F} into a W_D-bit two's-complement value (S ? -1 : 1) * (F << E),
// one shift per cycle, with valid/ready handshakes on both sides.
module fp_expand
    import fp_pkg::*;
#(
    parameter int unsigned W_D = fp_pkg::W_D,
    parameter int unsigned W_E = fp_pkg::W_E,
    parameter int unsigned W_F = fp_pkg::W_F
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic           in_s,
    input  logic [W_E-1:0] in_e,
    input  logic [W_F-1:0] in_f,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [W_D-1:0] out_d,
    output logic           busy
);

    state_t         state_q, state_d;
    logic [W_D-1:0] mag_q, mag_d;
    logic [W_E-1:0] cnt_q, cnt_d;
    logic           sgn_q, sgn_d;
    logic [W_D-1:0] out_d_q, out_d_d;
    logic           out_valid_q, out_valid_d;

    always_comb begin
        state_d     = state_q;
        mag_d       = mag_q;
        cnt_d       = cnt_q;
        sgn_d       = sgn_q;
        out_d_d     = out_d_q;
        out_valid_d = out_valid_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    mag_d   = W_D'(in_f);
                    cnt_d   = in_e;
                    sgn_d   = in_s;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (cnt_q != '0) begin
                    mag_d = mag_q << 1;
                    cnt_d = cnt_q - W_E'(1);
                end else begin
                    // Negating a zero magnitude wraps back to zero, so -0 never appears.
                    out_d_d     = sgn_q ? (~mag_q + W_D'(1)) : mag_q;
                    out_valid_d = 1'b1;
                    state_d     = OUT;
                end
            end
            OUT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            mag_q       <= '0;
            cnt_q       <= '0;
            sgn_q       <= 1'b0;
            out_d_q     <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            mag_q       <= mag_d;
            cnt_q       <= cnt_d;
            sgn_q       <= sgn_d;
            out_d_q     <= out_d_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign out_valid = out_valid_q;
    assign out_d     = out_d_q;

endmodule

// File: tb/tb_fp_expand.sv
// Directed and randomized checks of fp_expand against an arithmetic reference model.
module tb_fp_expand;
    import fp_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_s = 1'b0;
    logic [2:0]  in_e = '0;
    logic [4:0]  in_f = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [12:0] out_d;
    logic        busy;

    int errors = 0;
    int checks = 0;

    fp_expand #(.W_D(13), .W_E(3), .W_F(5)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_s(in_s), .in_e(in_e), .in_f(in_f),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_d(out_d), .busy(busy)
    );

    always #5 clk = ~clk;

    // Reference: signed integer product reduced modulo 2^13.
    function automatic logic [12:0] ref_val(input logic s, input int e, input int f);
        int v;
        v = f * (1 << e);
        if (s) v = -v;
        return 13'(v);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Presents one code, drops in_valid after the accepting edge, and checks latency and value.
    task automatic accept(input logic s, input int e, input int f, input string tag);
        int guard;
        guard = 0;
        in_valid = 1'b1; in_s = s; in_e = 3'(e); in_f = 5'(f);
        while (!in_ready && guard < 50) begin step(); guard++; end
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0; in_s = 1'($urandom); in_e = 3'($urandom); in_f = 5'($urandom);
    endtask

    task automatic await_result(input int e, input logic [12:0] exp_d, input string tag);
        int lat;
        lat = 0;
        while (!out_valid && lat < 20) begin step(); lat++; end
        chk({tag, "_latency"}, 32'(lat), 32'(e + 1));
        chk({tag, "_out_d"}, 32'(out_d), 32'(exp_d));
    endtask

    task automatic consume(input int stalls, input logic [12:0] exp_d, input string tag);
        out_ready = 1'b0;
        for (int i = 0; i < stalls; i++) begin
            step();
            chk({tag, "_stall_valid"}, 32'(out_valid), 32'd1);
            chk({tag, "_stall_d"}, 32'(out_d), 32'(exp_d));
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk({tag, "_done_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_done_ready"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        int order [512];
        int tmp, j, s, e, f;

        // Reset state
        rst = 1'b1; step(); step(); rst = 1'b0;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_d", 32'(out_d), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);

        // Basic positive value
        accept(1'b0, 3, 22, "t1");
        chk("t1_busy", 32'(busy), 32'd1);
        chk("t1_not_ready", 32'(in_ready), 32'd0);
        await_result(3, 13'h0B0, "t1");
        consume(0, 13'h0B0, "t1");

        // Largest negative magnitude
        accept(1'b1, 7, 31, "t2");
        await_result(7, 13'h1080, "t2");
        consume(0, 13'h1080, "t2");

        // Zero significand with either sign
        accept(1'b0, 0, 0, "t3p");
        await_result(0, 13'h000, "t3p");
        consume(0, 13'h000, "t3p");
        accept(1'b1, 0, 0, "t3n");
        await_result(0, 13'h000, "t3n");
        consume(0, 13'h000, "t3n");

        // Backpressure with a competing input request
        accept(1'b0, 2, 5, "t4a");
        await_result(2, 13'd20, "t4a");
        in_valid = 1'b1; in_s = 1'b1; in_e = 3'd1; in_f = 5'd3;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("t4_hold_d", 32'(out_d), 32'd20);
            chk("t4_hold_valid", 32'(out_valid), 32'd1);
            chk("t4_hold_in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1; step(); out_ready = 1'b0;
        chk("t4_release_valid", 32'(out_valid), 32'd0);
        chk("t4_release_ready", 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        chk("t4b_busy", 32'(busy), 32'd1);
        await_result(1, 13'h1FFA, "t4b");
        consume(1, 13'h1FFA, "t4b");

        // Reset during SHIFT discards the in-flight value
        accept(1'b0, 6, 17, "t5");
        step(); step();
        chk("t5_busy_mid", 32'(busy), 32'd1);
        rst = 1'b1; step(); rst = 1'b0;
        chk("t5_rst_busy", 32'(busy), 32'd0);
        chk("t5_rst_valid", 32'(out_valid), 32'd0);
        chk("t5_rst_d", 32'(out_d), 32'd0);
        chk("t5_rst_ready", 32'(in_ready), 32'd1);
        step();
        chk("t5_idle_valid", 32'(out_valid), 32'd0);
        accept(1'b0, 1, 1, "t5b");
        await_result(1, 13'd2, "t5b");
        consume(0, 13'd2, "t5b");

        // Every code in shuffled order with random output stalls
        for (int i = 0; i < 512; i++) order[i] = i;
        for (int i = 511; i > 0; i--) begin
            j = int'($urandom_range(i, 0));
            tmp = order[i]; order[i] = order[j]; order[j] = tmp;
        end
        for (int i = 0; i < 512; i++) begin
            s = (order[i] >> 8) & 1;
            e = (order[i] >> 5) & 7;
            f = order[i] & 31;
            accept(1'(s), e, f, "sweep");
            await_result(e, ref_val(1'(s), e, f), "sweep");
            consume(int'($urandom_range(3, 0)), ref_val(1'(s), e, f), "sweep");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fp_expand.md
Name: fp_expand

Overview:
- Downstream companion to the 13-bit-to-float compressor. Consumes a compressed value {S, E[2:0], F[4:0]} and reconstructs the 13-bit two's-complement integer D = (S ? -1 : +1) * (F << E).
- Built sequentially: an iterative one-bit-per-cycle left shifter driven by a small FSM.
- Valid/ready handshakes on both input and output, so it can sit between the compressor and a display/accumulator stage with backpressure.

Parameters:
- W_D, 13, width of reconstructed two's-complement output.
- W_E, 3, exponent width (shift count range 0..7).
- W_F, 5, significand width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  upstream presents S/E/F.
- in_ready  out  1  block can accept a new value.
- in_s  in  1  sign bit.
- in_e  in  3  exponent.
- in_f  in  5  significand.
- out_valid  out  1  out_d holds a completed result.
- out_ready  in  1  downstream accepts out_d.
- out_d  out  13  reconstructed two's-complement value.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (rst=1 at a rising edge): state=IDLE; out_valid=0; out_d=0; busy=0; internal mag, cnt and sgn cleared. Applies from any state, including mid-SHIFT or OUT with out_ready low. Any in-flight result is discarded.
- in_ready = (state==IDLE), combinational from the state register. There is no same-cycle bypass from OUT to IDLE.
- States: IDLE, SHIFT, OUT.
- IDLE:
  - On an edge with in_valid & in_ready: mag <= {8'b0, in_f} (13 bits); cnt <= in_e; sgn <= in_s; state -> SHIFT.
  - Otherwise stay in IDLE.
  - Inputs need not be held after acceptance.
- SHIFT:
  - Each edge with cnt != 0: mag <= mag << 1; cnt <= cnt - 1.
  - Edge with cnt == 0: out_d <= sgn ? (~mag + 1) : mag, computed mod 2^13; out_valid <= 1; state -> OUT.
- OUT:
  - out_valid and out_d are held stable while out_ready=0.
  - On an edge with out_ready=1: out_valid <= 0; state -> IDLE. out_d keeps its last value, which is don't-care when out_valid=0.
- Latency: out_valid rises E+1 edges after the accepting edge (E=0 gives 1, E=7 gives 8).
- Minimum initiation interval: E+3 cycles with out_ready tied high.
- Width rules:
  - The largest magnitude is 31<<7 = 3968 (12 bits), so no overflow or saturation is possible.
  - -3968 = 13'h1080.
  - S=1 with F=0 yields 0, never 13'h1000.
- Simultaneous events:
  - in_valid asserted while not IDLE is ignored; upstream must hold it until in_ready.
  - rst has priority over every handshake.
- busy = (state != IDLE).

Decomposition:
- Shared package fp_pkg: constants W_D=13, W_E=3, W_F=5; the state enum {IDLE, SHIFT, OUT}; a MAX_MAG=3968 constant for benches.
- Single module. The shifter and FSM are too small to justify a sub-module.

Test Plan:
- S=0,E=3,F=22 accepted, out_ready=1 -> out_valid 4 cycles after accept, out_d=13'h0B0 (176), in_ready high the cycle after the output handshake.
- S=1,E=7,F=31 -> out_d=13'h1080 (-3968), latency 8.
- S=0,E=0,F=0 and S=1,E=0,F=0 -> out_d=0 both times, latency 1.
- S=0,E=2,F=5: hold out_ready=0 for 5 cycles while pulsing in_valid with S=1,E=1,F=3 -> out_d stays 20, in_ready=0, second value not accepted; it is accepted only after out_ready and returns -6 = 13'h1FFA.
- Assert rst during SHIFT of E=6 -> next cycle state=IDLE, out_valid=0, out_d=0, busy=0, in_ready=1; a following S=0,E=1,F=1 returns 2.
- Randomised sweep of all 512 {S,E,F} codes with random out_ready stalls -> every out_d equals the reference model (S ? -(F<<E) : F<<E) mod 2^13, in order, with no loss or duplication.
